// File: rtl/wisc_pkg.sv
// Shared constants and types for the IF/ID boundary stage.
package wisc_pkg;

    localparam int unsigned XLEN = 16;

    // Opcode field of an instruction word.
    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 11;

    localparam logic [XLEN-1:0]          NOP_INSTR = 16'h0800;
    localparam logic [OPC_HI-OPC_LO:0]   HALT_OPC  = 5'b00000;

    typedef enum logic [0:0] {
        RUN        = 1'b0,
        HALT_DRAIN = 1'b1
    } fd_state_t;

    // One buffered fetch entry: 48 bits.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inc_pc;
    } fd_entry_t;

endpackage

// File: rtl/fd_ring.sv
// DEPTH-entry ring buffer of fetch entries with wrapping pointers,
// occupancy count and full/empty flags. clr empties it synchronously.
module fd_ring
    import wisc_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clr,
    input  logic      wr_en,
    input  fd_entry_t wr_data,
    input  logic      rd_en,
    output fd_entry_t rd_data,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    fd_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;

    // Next pointer/count: clear wins, otherwise advance on write/read.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write.
    // NOTE: storage has no reset; an entry is only observable once count
    // covers it, so resetting the array would only add reset fanout.
    always_ff @(posedge clk) begin
        if (wr_en && !clr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/fetch_decode_latch.sv
// IF/ID boundary stage: buffers fetched {instr, pc, pc+2} entries in a
// small ring with valid/ready handshake, supports flush and HALT freeze,
// and flags misaligned PCs in a sticky err bit.
// Optional zero-latency bypass when empty: define FD_BYPASS_EN.
module fetch_decode_latch
    import wisc_pkg::*;
#(
    parameter int unsigned               DEPTH     = 2,
    parameter logic [XLEN-1:0]           NOP_INSTR = wisc_pkg::NOP_INSTR,
    parameter logic [OPC_HI-OPC_LO:0]    HALT_OPC  = wisc_pkg::HALT_OPC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [15:0]     if_instr,
    input  logic [15:0]     if_pc,
    input  logic [15:0]     if_inc_pc,
    output logic            if_ready,
    input  logic            flush,
    input  logic            id_stall,
    output logic            id_valid,
    output logic [15:0]     id_instr,
    output logic [15:0]     id_pc,
    output logic [15:0]     id_inc_pc,
    output logic            halted,
    output logic            err
);

    fd_state_t state_q, state_d;
    logic      err_q, err_d;

    logic      push, pop, wr_en, rd_en, bypass_act;
    logic      full, empty, is_halt;
    fd_entry_t in_entry, head;

    assign in_entry = '{instr: if_instr, pc: if_pc, inc_pc: if_inc_pc};
    assign is_halt  = (if_instr[OPC_HI:OPC_LO] == HALT_OPC);

    // Handshake: if_ready depends only on registered state, never on pop.
    always_comb begin
        if_ready = (state_q == RUN) && !full;
`ifdef FD_BYPASS_EN
        bypass_act = rst && empty && (state_q == RUN) && if_valid && !flush;
`else
        bypass_act = 1'b0;
`endif
        push     = if_valid && if_ready && !flush;
        id_valid = !empty || bypass_act;
        pop      = id_valid && !id_stall && !flush;
        // A bypassed entry consumed this cycle is never written.
        wr_en    = push && !(bypass_act && !id_stall);
        rd_en    = pop && !empty;
    end

    // Decode-side view: bypass, buffered head, or NOP when empty.
    always_comb begin
        id_instr  = NOP_INSTR;
        id_pc     = '0;
        id_inc_pc = '0;
        if (bypass_act) begin
            id_instr  = if_instr;
            id_pc     = if_pc;
            id_inc_pc = if_inc_pc;
        end else if (!empty) begin
            id_instr  = head.instr;
            id_pc     = head.pc;
            id_inc_pc = head.inc_pc;
        end
    end

    // FSM and sticky error next state: flush beats HALT detection.
    always_comb begin
        state_d = state_q;
        if (flush)                 state_d = RUN;
        else if (push && is_halt)  state_d = HALT_DRAIN;
        err_d = err_q || (push && if_pc[0]);
    end

    // State and error registers.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign halted = (state_q == HALT_DRAIN);
    assign err    = err_q;

    fd_ring #(.DEPTH(DEPTH)) u_ring (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .wr_en   (wr_en),
        .wr_data (in_entry),
        .rd_en   (rd_en),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_fetch_decode_latch.sv
// Directed table-driven bench for fetch_decode_latch (DEPTH=2).
module tb_fetch_decode_latch;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, flush, id_stall;
    logic [15:0] if_instr, if_pc, if_inc_pc;
    logic        if_ready, id_valid, halted, err;
    logic [15:0] id_instr, id_pc, id_inc_pc;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [15:0] NOP = 16'h0800;

    always #5 clk = ~clk;

    fetch_decode_latch #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_inc_pc(if_inc_pc), .if_ready(if_ready), .flush(flush),
        .id_stall(id_stall), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_inc_pc(id_inc_pc), .halted(halted), .err(err)
    );

    typedef struct {
        logic        iv;
        logic [15:0] instr;
        logic [15:0] pc;
        logic        stall;
        logic        fl;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_pc;
        logic        e_ready;
        logic        e_halted;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [15:0] instr, input logic [15:0] pc,
                         input logic stall, input logic fl);
        if_valid  = iv;
        if_instr  = instr;
        if_pc     = pc;
        if_inc_pc = pc + 16'd2;
        id_stall  = stall;
        flush     = fl;
    endtask

    task automatic check_outs(input string tag, input logic e_valid, input logic [15:0] e_instr,
                              input logic [15:0] e_pc, input logic e_ready,
                              input logic e_halted, input logic e_err);
        check({tag, ".id_valid"},  16'(id_valid),  16'(e_valid));
        check({tag, ".id_instr"},  id_instr,       e_instr);
        check({tag, ".id_pc"},     id_pc,          e_pc);
        check({tag, ".id_inc_pc"}, id_inc_pc,      e_valid ? e_pc + 16'd2 : 16'h0000);
        check({tag, ".if_ready"},  16'(if_ready),  16'(e_ready));
        check({tag, ".halted"},    16'(halted),    16'(e_halted));
        check({tag, ".err"},       16'(err),       16'(e_err));
    endtask

    // Stimulus record; expected outputs are those seen before the edge.
    task automatic add(input logic iv, input logic [15:0] instr, input logic [15:0] pc,
                       input logic stall, input logic fl, input logic e_valid,
                       input logic [15:0] e_instr, input logic [15:0] e_pc,
                       input logic e_ready, input logic e_halted, input logic e_err);
        vec_t v;
        v = '{iv, instr, pc, stall, fl, e_valid, e_instr, e_pc, e_ready, e_halted, e_err};
        vecs.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        check_outs("in_reset", 0, NOP, 16'h0, 1, 0, 0);
        tick;
        tick;
        rst = 1'b1;
        #1;
        check_outs("post_reset", 0, NOP, 16'h0, 1, 0, 0);

`ifndef FD_BYPASS_EN
        //   iv  instr     pc        stl fl | val instr     pc        rdy hlt err
        // single push, one-cycle latency
        add(1, 16'hC005, 16'h0010, 0, 0,   0, NOP,      16'h0000, 1, 0, 0);
        add(0, 16'h0000, 16'h0000, 0, 0,   1, 16'hC005, 16'h0010, 1, 0, 0);
        add(0, 16'h0000, 16'h0000, 0, 0,   0, NOP,      16'h0000, 1, 0, 0);
        // stall, fill, third push ignored, drain in order
        add(1, 16'h1111, 16'h0000, 1, 0,   0, NOP,      16'h0000, 1, 0, 0);
        add(1, 16'h2222, 16'h0002, 1, 0,   1, 16'h1111, 16'h0000, 1, 0, 0);
        add(1, 16'h3333, 16'h0004, 1, 0,   1, 16'h1111, 16'h0000, 0, 0, 0);
        add(0, 16'h0000, 16'h0000, 0, 0,   1, 16'h1111, 16'h0000, 0, 0, 0);
        add(0, 16'h0000, 16'h0000, 0, 0,   1, 16'h2222, 16'h0002, 1, 0, 0);
        add(0, 16'h0000, 16'h0000, 0, 0,   0, NOP,      16'h0000, 1, 0, 0);
        // fill then flush with if_valid; then flush beats a legal push
        add(1, 16'h4444, 16'h0040, 1, 0,   0, NOP,      16'h0000, 1, 0, 0);
        add(1, 16'h5555, 16'h0042, 1, 0,   1, 16'h4444, 16'h0040, 1, 0, 0);
        add(1, 16'h6666, 16'h0020, 1, 1,   1, 16'h4444, 16'h0040, 0, 0, 0);
        add(1, 16'h7777, 16'h0050, 0, 1,   0, NOP,      16'h0000, 1, 0, 0);
        add(0, 16'h0000, 16'h0000, 0, 0,   0, NOP,      16'h0000, 1, 0, 0);
        // HALT accepted, delivered, further fetch ignored until flush
        add(1, 16'h0000, 16'h0030, 1, 0,   0, NOP,      16'h0000, 1, 0, 0);
        add(1, 16'h8888, 16'h0032, 1, 0,   1, 16'h0000, 16'h0030, 0, 1, 0);
        add(0, 16'h0000, 16'h0000, 0, 0,   1, 16'h0000, 16'h0030, 0, 1, 0);
        add(1, 16'h8888, 16'h0032, 0, 0,   0, NOP,      16'h0000, 0, 1, 0);
        add(0, 16'h0000, 16'h0000, 0, 1,   0, NOP,      16'h0000, 0, 1, 0);
        add(0, 16'h0000, 16'h0000, 0, 0,   0, NOP,      16'h0000, 1, 0, 0);
        // misaligned PC: entry stored, err sticky through flush
        add(1, 16'h9999, 16'h0031, 0, 0,   0, NOP,      16'h0000, 1, 0, 0);
        add(0, 16'h0000, 16'h0000, 0, 0,   1, 16'h9999, 16'h0031, 1, 0, 1);
        add(0, 16'h0000, 16'h0000, 0, 1,   0, NOP,      16'h0000, 1, 0, 1);
        add(0, 16'h0000, 16'h0000, 0, 0,   0, NOP,      16'h0000, 1, 0, 1);
        // streaming push+pop: pointers wrap, FIFO order kept
        add(1, 16'hAAAA, 16'h0100, 0, 0,   0, NOP,      16'h0000, 1, 0, 1);
        add(1, 16'hBBBB, 16'h0102, 0, 0,   1, 16'hAAAA, 16'h0100, 1, 0, 1);
        add(1, 16'hCCCC, 16'h0104, 0, 0,   1, 16'hBBBB, 16'h0102, 1, 0, 1);
        add(0, 16'h0000, 16'h0000, 0, 0,   1, 16'hCCCC, 16'h0104, 1, 0, 1);
        add(0, 16'h0000, 16'h0000, 0, 0,   0, NOP,      16'h0000, 1, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].instr, vecs[i].pc, vecs[i].stall, vecs[i].fl);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr,
                       vecs[i].e_pc, vecs[i].e_ready, vecs[i].e_halted, vecs[i].e_err);
            tick;
        end
`else
        // Bypass: empty and unstalled -> same-cycle delivery, not stored.
        drive(1, 16'hC005, 16'h0010, 0, 0);
        #1;
        check_outs("byp_same", 1, 16'hC005, 16'h0010, 1, 0, 0);
        tick;
        drive(0, 16'h0000, 16'h0000, 0, 0);
        #1;
        check_outs("byp_consumed", 0, NOP, 16'h0000, 1, 0, 0);
        tick;
        // Bypass while stalled: shown now, also written; err still applied.
        drive(1, 16'h9999, 16'h0031, 1, 0);
        #1;
        check_outs("byp_stall", 1, 16'h9999, 16'h0031, 1, 0, 0);
        tick;
        drive(0, 16'h0000, 16'h0000, 0, 0);
        #1;
        check_outs("byp_stored", 1, 16'h9999, 16'h0031, 1, 0, 1);
        tick;
        drive(0, 16'h0000, 16'h0000, 0, 1);
        tick;
        drive(0, 16'h0000, 16'h0000, 0, 0);
        #1;
        check_outs("byp_flush_err", 0, NOP, 16'h0000, 1, 0, 1);
        tick;
`endif

        // Asynchronous reset mid-cycle drops buffered entries at once.
        drive(1, 16'hD00D, 16'h0200, 1, 0);
        tick;
        drive(1, 16'hE00E, 16'h0202, 1, 0);
        tick;
        drive(0, 16'h0000, 16'h0000, 1, 0);
        #1;
        check_outs("full_before_rst", 1, 16'hD00D, 16'h0200, 0, 0, 1);
        #1;
        rst = 1'b0;
        #1;
        check_outs("async_rst", 0, NOP, 16'h0000, 1, 0, 0);
        #1;
        rst = 1'b1;
        tick;
        check_outs("after_rst", 0, NOP, 16'h0000, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
